// File: rtl/fir_frame_collector_if.sv
// FIR-to-FFT frame collector bus: sample stream in, 256-bit frame out with valid/ready.
// slave is the collector's view; master is the driving side (FIR/FFT or bench).
interface fir_frame_collector_if #(
  parameter int SAMPLE_W = 16,
  parameter int FRAME_N  = 16
);
  logic                         fir_valid;
  logic [SAMPLE_W-1:0]          fir_d;
  logic                         frame_ready;
  logic                         frame_valid;
  logic [SAMPLE_W*FRAME_N-1:0]  frame_data;
  logic                         overflow;

  modport master (
    output fir_valid, fir_d, frame_ready,
    input  frame_valid, frame_data, overflow
  );

  modport slave (
    input  fir_valid, fir_d, frame_ready,
    output frame_valid, frame_data, overflow
  );
endinterface

// File: rtl/fir_frame_collector.sv
// Ping-pong frame buffer collecting FRAME_N FIR samples per bank for the FFT.
// Optional FRAME_BITREV_EN: write each sample to its bit-reversed slot (DIT input order).
module fir_frame_collector #(
  parameter int SAMPLE_W = 16,
  parameter int FRAME_N  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_frame_collector_if.slave bus
);
  localparam int IDX_W = $clog2(FRAME_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_N - 1);

  logic [1:0][FRAME_N-1:0][SAMPLE_W-1:0] bank;
  logic                                  wr_bank;
  logic                                  rd_bank;
  logic [IDX_W-1:0]                      wr_idx;
  logic [IDX_W-1:0]                      wr_slot;
  logic [1:0]                            full;
  logic [1:0]                            full_next;
  logic                                  overflow_q;
  logic                                  accept;
  logic                                  drop;
  logic                                  handshake;
  logic                                  complete;

`ifdef FRAME_BITREV_EN
  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < IDX_W; b++) begin
      r[b] = i[IDX_W-1-b];
    end
    return r;
  endfunction
`endif

  always_comb begin
    accept    = bus.fir_valid && !full[wr_bank];
    drop      = bus.fir_valid &&  full[wr_bank];
    handshake = full[rd_bank] && bus.frame_ready;
    complete  = accept && (wr_idx == LAST_IDX);
`ifdef FRAME_BITREV_EN
    wr_slot   = bitrev(wr_idx);
`else
    wr_slot   = wr_idx;
`endif
    // A handshake and a completion in the same cycle always target different banks.
    full_next = full;
    if (handshake) full_next[rd_bank] = 1'b0;
    if (complete)  full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_idx     <= '0;
      full       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        bank[wr_bank][wr_slot] <= bus.fir_d;
        wr_idx                 <= complete ? '0 : wr_idx + 1'b1;
        if (complete) wr_bank <= ~wr_bank;
      end
      if (drop)      overflow_q <= 1'b1;
      if (handshake) rd_bank    <= ~rd_bank;
      full <= full_next;
    end
  end

  assign bus.frame_valid = full[rd_bank];
  assign bus.frame_data  = bank[rd_bank];
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_fir_frame_collector.sv
// Bench for fir_frame_collector: directed scenarios plus random traffic against a frame-queue model.
module tb_fir_frame_collector;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  fir_frame_collector_if #(.SAMPLE_W(16), .FRAME_N(16)) bus ();

  fir_frame_collector #(.SAMPLE_W(16), .FRAME_N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: queue of completed frames (at most two), frame under construction, sticky overflow.
  logic [255:0] q[$];
  logic [255:0] cur;
  int           pcnt;
  bit           ovf;

  function automatic int slot_of(input int i);
`ifdef FRAME_BITREV_EN
    return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
`else
    return i;
`endif
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    cur  = '0;
    pcnt = 0;
    ovf  = 1'b0;
  endtask

  // Check outputs for the current cycle, then drive inputs and advance the model past the next edge.
  task automatic step(input bit v, input logic [15:0] d, input bit r);
    bit drop, hs, comp;
    @(negedge clk);
    chk("frame_valid", 256'(bus.frame_valid), 256'(q.size() > 0));
    chk("overflow", 256'(bus.overflow), 256'(ovf));
    if (q.size() > 0) chk("frame_data", bus.frame_data, q[0]);
    bus.fir_valid   = v;
    bus.fir_d       = d;
    bus.frame_ready = r;
    drop = v && (q.size() == 2);
    hs   = (q.size() > 0) && r;
    comp = 1'b0;
    if (v && !drop) begin
      cur[16*slot_of(pcnt) +: 16] = d;
      pcnt++;
      if (pcnt == 16) begin
        comp = 1'b1;
        pcnt = 0;
      end
    end
    if (drop) ovf = 1'b1;
    if (hs) void'(q.pop_front());
    if (comp) q.push_back(cur);
  endtask

  task automatic check_reset_outputs();
    chk("rst_frame_valid", 256'(bus.frame_valid), 256'(0));
    chk("rst_overflow", 256'(bus.overflow), 256'(0));
    chk("rst_frame_data", bus.frame_data, 256'(0));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    bus.fir_valid   = 1'b0;
    bus.fir_d       = '0;
    bus.frame_ready = 1'b0;
    #1;
    check_reset_outputs();
    repeat (n) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    model_clear();
  endtask

`ifndef FRAME_BITREV_EN
  task automatic chk_slots_seq(input string tag, input int base);
    logic [255:0] fd;
    fd = bus.frame_data;
    for (int k = 0; k < 16; k++) chk(tag, 256'(fd[16*k +: 16]), 256'(16'(base + k)));
  endtask
`endif

  initial begin
    logic [255:0] fd;
    rst = 1'b0;
    bus.fir_valid   = 1'b0;
    bus.fir_d       = '0;
    bus.frame_ready = 1'b0;
    model_clear();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back 1..16 with ready held high
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b1);
    step(1'b0, '0, 1'b1);
`ifdef FRAME_BITREV_EN
    fd = bus.frame_data;
    chk("bitrev_slot0", 256'(fd[15:0]), 256'(1));
    chk("bitrev_slot1", 256'(fd[31:16]), 256'(9));
    chk("bitrev_slot8", 256'(fd[143:128]), 256'(2));
    chk("bitrev_slot15", 256'(fd[255:240]), 256'(16));
`else
    chk_slots_seq("nat_slot", 1);
`endif
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Backpressure: 33 samples with ready low, 33rd dropped
    do_reset(1);
    for (int i = 1; i <= 33; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    chk("bp_overflow", 256'(bus.overflow), 256'(1));
`ifndef FRAME_BITREV_EN
    chk_slots_seq("bp_frame_a", 1);
`endif
    step(1'b0, '0, 1'b1);
`ifndef FRAME_BITREV_EN
    chk_slots_seq("bp_frame_b", 17);
`endif
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Gapped input, extreme alternating values
    do_reset(1);
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) step(1'b1, ((i / 2) % 2 == 0) ? 16'h8000 : 16'h7fff, 1'b1);
      else            step(1'b0, '0, 1'b1);
    end
`ifndef FRAME_BITREV_EN
    fd = bus.frame_data;
    chk("gap_valid", 256'(bus.frame_valid), 256'(1));
    for (int k = 0; k < 16; k++)
      chk("gap_slot", 256'(fd[16*k +: 16]), 256'((k % 2 == 0) ? 16'h8000 : 16'h7fff));
`endif
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Reset mid-frame, then 100..115
    for (int i = 0; i < 7; i++) step(1'b1, 16'(500 + i), 1'b0);
    do_reset(2);
    for (int i = 0; i < 16; i++) step(1'b1, 16'(100 + i), 1'b0);
    step(1'b0, '0, 1'b0);
`ifndef FRAME_BITREV_EN
    chk_slots_seq("rst_mid_slot", 100);
`endif
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Ready raised on the edge the second bank completes
    do_reset(1);
    for (int i = 1; i <= 31; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b1, 16'(32), 1'b1);
    step(1'b1, 16'(33), 1'b1);
    chk("simul_valid", 256'(bus.frame_valid), 256'(1));
`ifndef FRAME_BITREV_EN
    chk_slots_seq("simul_frame_b", 17);
`endif
    for (int i = 34; i <= 48; i++) step(1'b1, 16'(i), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("simul_no_loss", 256'(bus.overflow), 256'(0));

    // Random traffic
    do_reset(1);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) < 4));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
